// File: rtl/ecm24_spi_arbiter_pkg.sv
// Shared types for the two-master SPI pad arbiter.
package ecm24_spi_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int MIDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef logic [MIDX_W-1:0] master_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Signals one master presents towards the pads.
    typedef struct packed {
        logic clk;
        logic mosi;
        logic cs_n;
    } pad_t;

endpackage

// File: rtl/ecm24_spi_arbiter_if.sv
// Master-side and pad-side SPI signals of the arbiter, bundled.
interface ecm24_spi_arbiter_if;
    import ecm24_spi_pkg::*;

    logic [NUM_MASTERS-1:0] m_req;
    logic [NUM_MASTERS-1:0] m_gnt;
    logic [NUM_MASTERS-1:0] m_spi_clk;
    logic [NUM_MASTERS-1:0] m_spi_mosi;
    logic [NUM_MASTERS-1:0] m_spi_cs_n;
    logic [NUM_MASTERS-1:0] m_spi_miso;
    logic                   spi_miso;
    logic                   spi_clk;
    logic                   spi_mosi;
    logic                   spi_cs1;
    logic                   spi_cs2;

    // Arbiter side.
    modport slave (
        input  m_req, m_spi_clk, m_spi_mosi, m_spi_cs_n, spi_miso,
        output m_gnt, m_spi_miso, spi_clk, spi_mosi, spi_cs1, spi_cs2
    );

    // Masters and pad side.
    modport master (
        output m_req, m_spi_clk, m_spi_mosi, m_spi_cs_n, spi_miso,
        input  m_gnt, m_spi_miso, spi_clk, spi_mosi, spi_cs1, spi_cs2
    );

endinterface

// File: rtl/ecm24_rr_pick.sv
// Combinational round-robin winner select between two requesters.
module ecm24_rr_pick
    import ecm24_spi_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  master_idx_t            last,
    output logic                   vld,
    output master_idx_t            win
);

    always_comb begin
        vld = |req;
        win = last;
        case (req)
            2'b01:   win = '0;
            2'b10:   win = master_idx_t'(1);
            2'b11:   win = ~last;   // tie goes to whoever did not own last
            default: win = last;
        endcase
    end

endmodule

// File: rtl/ecm24_spi_arbiter.sv
// Round-robin owner of the shared SPI pads with a chip-select-high gap
// between owners and sticky flags for masters driving cs_n without a grant.
module ecm24_spi_arbiter
    import ecm24_spi_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int GAP_W      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst,
    ecm24_spi_arbiter_if.slave     bus,
    output logic                   busy,
    output logic [NUM_MASTERS-1:0] err
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_GRANT = GRANT;
    localparam logic [1:0] ST_GAP   = GAP;

    logic [1:0]             state_q, state_d;
    master_idx_t            owner_q, owner_d;
    master_idx_t            last_q, last_d;
    logic [GAP_W-1:0]       cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [NUM_MASTERS-1:0] sel;
    logic                   pick_vld;
    master_idx_t            pick_win;
    logic                   release_ok;
    pad_t                   own_pad;

    ecm24_rr_pick u_pick (
        .req  (bus.m_req),
        .last (last_q),
        .vld  (pick_vld),
        .win  (pick_win)
    );

    // An aborting owner keeps the bus until its cs_n is back high.
    assign release_ok = !bus.m_req[owner_q] && bus.m_spi_cs_n[owner_q];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_GRANT;
                    owner_d = pick_win;
                    last_d  = pick_win;
                end
            end
            ST_GRANT: begin
                if (release_ok) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_W'(GAP_CYCLES - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant is registered from next-state so it always matches state_q/owner_q.
    always_comb begin
        gnt_d = '0;
        if (state_d == ST_GRANT) gnt_d[owner_d] = 1'b1;
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= master_idx_t'(1);
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_sel
        assign sel[i] = (state_q == ST_GRANT) && (owner_q == master_idx_t'(i));
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) err <= '0;
        else        err <= err | (~bus.m_spi_cs_n & ~gnt_q);
    end

    assign own_pad = '{clk:  bus.m_spi_clk[owner_q],
                       mosi: bus.m_spi_mosi[owner_q],
                       cs_n: bus.m_spi_cs_n[owner_q]};

    always_comb begin
        bus.spi_clk  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_cs1  = 1'b1;
        bus.spi_cs2  = 1'b1;
        if (state_q == ST_GRANT) begin
            bus.spi_clk  = own_pad.clk;
            bus.spi_mosi = own_pad.mosi;
            if (owner_q == '0) bus.spi_cs1 = own_pad.cs_n;
            else               bus.spi_cs2 = own_pad.cs_n;
        end
    end

    assign bus.m_gnt      = gnt_q;
    assign bus.m_spi_miso = sel & {NUM_MASTERS{bus.spi_miso}};
    assign busy           = (state_q != ST_IDLE);

endmodule
